vga_pixel_gen: RTL and testbench
================================

VGA_PIXEL_GEN -- requirements
Module: vga_pixel_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-003 Parameter BOX_SIZE, 32, bouncing-box edge length in pixels.
REQ-004 Parameter STEP, 2, box displacement per frame on each axis, in pixels.
REQ-005 clk  input  1  system clock, 50 MHz; one clock; all state SHALL be updated on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pix_clk  input  1  pixel clock from the sync generator; a clk/2 square wave used as a level signal, not as a clock.
REQ-008 hcount  input  10  horizontal pixel position from the sync generator.
REQ-009 vcount  input  10  vertical line position from the sync generator.
REQ-010 blank  input  1  1 = outside the visible area.
REQ-011 hsync  input  1  horizontal sync from the sync generator, active low.
REQ-012 vsync  input  1  vertical sync from the sync generator, active low.
REQ-013 mode  input  2  pattern select: 00 colour bars, 01 checkerboard, 10 bouncing box, 11 solid white.
REQ-014 red  output  3  registered red level.
REQ-015 green  output  3  registered green level.
REQ-016 blue  output  2  registered blue level.
REQ-017 hsync_o  output  1  hsync delayed so it stays aligned with RGB.
REQ-018 vsync_o  output  1  vsync delayed so it stays aligned with RGB.
REQ-019 frame_cnt  output  8  count of frame starts since reset; wraps from 255 to 0.

Function
REQ-020 pix_q SHALL register pix_clk; pix_tick SHALL equal pix_clk & ~pix_q.
REQ-021 On a clk edge where pix_tick=1, the block SHALL sample hcount, vcount, blank, hsync and vsync, and SHALL load red, green, blue, hsync_o and vsync_o from them.
REQ-022 Latency SHALL be exactly one clk edge from the sampling cycle.
REQ-023 All outputs SHALL hold their values on every clk edge where pix_tick=0.
REQ-024 When blank=1, the sampled colour SHALL be red=0, green=0, blue=0, regardless of mode.
REQ-025 Colour bars: bar index i = hcount/80, range 0..7; colour SHALL be red={3{i[2]}}, green={3{i[1]}}, blue={2{i[0]}}.
REQ-026 Checkerboard: colour SHALL be white (all ones) when hcount[5]^vcount[5]=1, otherwise black.
REQ-027 Bouncing box: colour SHALL be white when box_x<=hcount<box_x+BOX_SIZE and box_y<=vcount<box_y+BOX_SIZE.
REQ-028 Bouncing box: colour SHALL otherwise be red=0, green=0, blue=3.
REQ-029 Solid white: colour SHALL be red=7, green=7, blue=3.
REQ-030 A frame start SHALL be a sampled vsync 1->0 transition: prev_vsync=1 and vsync=0 on a pix_tick cycle.
REQ-031 On each frame start, the block SHALL increment frame_cnt.
REQ-032 On each frame start, the block SHALL latch mode into mode_r; mode_r alone SHALL select the pattern, so a mode change mid-frame takes effect only at the next frame start.
REQ-033 On each frame start, the block SHALL advance the box position (REQ-034..037).
REQ-034 Horizontal motion, state x_dir (RIGHT/LEFT), case RIGHT: if box_x+STEP >= H_ACTIVE-BOX_SIZE, box_x SHALL become H_ACTIVE-BOX_SIZE and x_dir SHALL become LEFT; otherwise box_x SHALL become box_x+STEP.
REQ-035 Horizontal motion, case LEFT: if box_x <= STEP, box_x SHALL become 0 and x_dir SHALL become RIGHT; otherwise box_x SHALL become box_x-STEP.
REQ-036 Vertical motion (y_dir, DOWN/UP) SHALL follow the same rules as REQ-034..035, using V_ACTIVE and box_y.
REQ-037 The box SHALL never leave the visible area; clamping SHALL be evaluated in 11-bit arithmetic to avoid wrap.
REQ-038 Frame-start updates SHALL run in every mode, so the box position stays continuous across mode changes.
REQ-039 If a frame start and a pattern sample coincide, the colour SHALL use the pre-update box_x, box_y and mode_r.

Reset
REQ-040 While reset=1, outputs SHALL be red=0, green=0, blue=0, hsync_o=1, vsync_o=1, frame_cnt=0.
REQ-041 While reset=1, internal state SHALL be pix_q=0, prev_vsync=1, box_x=0, box_y=0, x_dir=RIGHT, y_dir=DOWN, mode_r=00.
REQ-042 Reset SHALL take priority over pix_tick; reset asserted mid-frame SHALL abort it, and the next frame start SHALL count as frame 1.

Verification
REQ-043 Bars: mode=00, latch 00 with one frame start, drive hcount=250, vcount=100, blank=0 -> one clk after the next pix_tick, red=0, green=7, blue=3 (i=3).
REQ-044 Blank/latency/hold: mode=11 latched, blank=1 -> RGB=0; then blank=0 -> RGB=7/7/3 exactly one clk after pix_tick; outputs unchanged on clk edges without pix_tick.
REQ-045 Bounce: mode=10, STEP=2, drive 304 frame starts -> box_x reaches 608 and x_dir=LEFT; after the next frame start, box_x=606.
REQ-046 Mode latch: frame 3 in progress with mode_r=00, switch mode to 01 -> pixels stay bars until the frame-4 vsync edge, then checkerboard; at hcount=32, vcount=0 the colour is white.
REQ-047 Reset mid-frame: reset after 5 frames -> frame_cnt=0, box at (0,0), hsync_o=1 and vsync_o=1 on the next edge; one frame start after release -> frame_cnt=1, box (2,2).
REQ-048 Sync alignment: toggle hsync at a pix_tick -> hsync_o follows on the same edge as RGB, i.e. one clk later.

Source files
------------

// File: rtl/vga_pixel_gen.sv
// Test-pattern pixel generator: samples the sync generator once per pixel and
// produces registered RGB plus delayed syncs. Four patterns are supported: colour
// bars, checkerboard, bouncing box and solid white. The pattern select and the box
// position only change at frame starts.
module vga_pixel_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_clk,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       blank,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [1:0] mode,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic [7:0] frame_cnt
);

    // Box limits are held in 11 bits so that pos+STEP cannot wrap.
    localparam logic [10:0] XMax = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] YMax = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Step = 11'(STEP);
    localparam logic [10:0] Size = 11'(BOX_SIZE);

    // The forward direction is RIGHT for x and DOWN for y.
    localparam logic DirFwd  = 1'b0;
    localparam logic DirBack = 1'b1;

    typedef enum logic [1:0] {
        ModeBars    = 2'b00,
        ModeChecker = 2'b01,
        ModeBox     = 2'b10,
        ModeWhite   = 2'b11
    } mode_e;

    logic       pix_q;
    logic       pix_tick;
    logic       prev_vsync;
    logic       frame_start;
    mode_e      mode_r;
    logic [9:0] box_x, box_y;
    logic       x_dir, y_dir;
    logic [9:0] box_x_d, box_y_d;
    logic       x_dir_d, y_dir_d;
    logic [2:0] bar;
    logic       in_box;
    logic [7:0] colour;     // {red, green, blue}

    // Advances one axis of the box. The result is {next_dir, next_pos}.
    function automatic logic [10:0] bounce(input logic [9:0] pos, input logic dir,
                                           input logic [10:0] lim);
        logic [10:0] p;
        p = {1'b0, pos};
        if (dir == DirFwd) begin
            if (p + Step >= lim) return {DirBack, 10'(lim)};
            else                 return {DirFwd, 10'(p + Step)};
        end else begin
            if (p <= Step) return {DirFwd, 10'd0};
            else           return {DirBack, 10'(p - Step)};
        end
    endfunction

    assign pix_tick    = pix_clk & ~pix_q;
    assign frame_start = pix_tick & prev_vsync & ~vsync;

    // Pattern colour for the current inputs, computed from the pre-update box and mode.
    always_comb begin
        bar    = 3'(hcount / 10'd80);
        in_box = ({1'b0, hcount} >= {1'b0, box_x}) && ({1'b0, hcount} < {1'b0, box_x} + Size) &&
                 ({1'b0, vcount} >= {1'b0, box_y}) && ({1'b0, vcount} < {1'b0, box_y} + Size);
        colour = 8'h00;
        if (!blank) begin
            unique case (mode_r)
                ModeBars:    colour = {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
                ModeChecker: colour = (hcount[5] ^ vcount[5]) ? 8'hFF : 8'h00;
                ModeBox:     colour = in_box ? 8'hFF : 8'h03;
                ModeWhite:   colour = 8'hFF;
                default:     colour = 8'h00;
            endcase
        end
    end

    // Next box position and direction, applied only at frame starts.
    always_comb begin
        {x_dir_d, box_x_d} = bounce(box_x, x_dir, XMax);
        {y_dir_d, box_y_d} = bounce(box_y, y_dir, YMax);
    end

    // Pixel pipeline: RGB and syncs load together on a pixel tick and hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q      <= 1'b0;
            prev_vsync <= 1'b1;
            red        <= 3'd0;
            green      <= 3'd0;
            blue       <= 2'd0;
            hsync_o    <= 1'b1;
            vsync_o    <= 1'b1;
        end else begin
            pix_q <= pix_clk;
            if (pix_tick) begin
                {red, green, blue} <= colour;
                hsync_o            <= hsync;
                vsync_o            <= vsync;
                prev_vsync         <= vsync;
            end
        end
    end

    // Per-frame state: counter, latched mode and box motion, in every mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= 8'd0;
            mode_r    <= ModeBars;
            box_x     <= 10'd0;
            box_y     <= 10'd0;
            x_dir     <= DirFwd;
            y_dir     <= DirFwd;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 8'd1;
            mode_r    <= mode_e'(mode);
            box_x     <= box_x_d;
            box_y     <= box_y_d;
            x_dir     <= x_dir_d;
            y_dir     <= y_dir_d;
        end
    end

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Bench for vga_pixel_gen: the driver pushes an expected {rgb, hsync, vsync} per
// checked pixel tick, and a monitor pops and compares one clk after that tick. The
// monitor also requires every output to hold across edges without a pixel tick.
module tb_vga_pixel_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_clk = 1'b0;
    logic       tb_pq = 1'b0;
    logic [9:0] hcount = 10'd0;
    logic [9:0] vcount = 10'd0;
    logic       blank = 1'b1;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       hsync_o, vsync_o;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [9:0]  exp_q[$];
    string       name_q[$];
    logic        m_tick, m_rst;
    logic [17:0] cur, last;
    logic [9:0]  e;
    string       nm;

    vga_pixel_gen dut (
        .clk       (clk),
        .reset     (reset),
        .pix_clk   (pix_clk),
        .hcount    (hcount),
        .vcount    (vcount),
        .blank     (blank),
        .hsync     (hsync),
        .vsync     (vsync),
        .mode      (mode),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o),
        .frame_cnt (frame_cnt)
    );

    always #10 clk = ~clk;

    // pix_clk is a clk/2 square wave; tb_pq mirrors the DUT's edge detector.
    always @(posedge clk) begin
        pix_clk <= ~pix_clk;
        tb_pq   <= pix_clk;
    end

    // Monitor: pop and compare after a pixel tick, otherwise require all outputs to hold.
    always @(posedge clk) begin
        m_tick = pix_clk & ~tb_pq;
        m_rst  = reset;
        #1;
        cur = {red, green, blue, hsync_o, vsync_o, frame_cnt};
        if (!m_rst) begin
            if (m_tick) begin
                if (exp_q.size() > 0) begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    checks++;
                    if (cur[17:8] !== e) begin
                        errors++;
                        $display("FAIL %s: got rgb/hs/vs %h expected %h", nm, cur[17:8], e);
                    end
                end
            end else begin
                checks++;
                if (cur !== last) begin
                    errors++;
                    $display("FAIL hold: got %h expected %h at %0t", cur, last, $time);
                end
            end
        end
        last = cur;
    end

    task automatic check_val(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // Step to the negedge of a clk cycle in which the pixel tick is high.
    task automatic wait_tick();
        @(negedge clk);
        while (!(pix_clk && !tb_pq)) @(negedge clk);
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic b,
                         input logic hs, input logic vs);
        wait_tick();
        hcount = h;
        vcount = v;
        blank  = b;
        hsync  = hs;
        vsync  = vs;
    endtask

    // Disturb inputs during the following non-tick cycle; outputs must not react.
    task automatic scramble();
        @(negedge clk);
        hcount = ~hcount;
        blank  = ~blank;
        hsync  = ~hsync;
    endtask

    task automatic tick_only(input logic [9:0] h, input logic [9:0] v, input logic b,
                             input logic hs, input logic vs);
        drive(h, v, b, hs, vs);
        scramble();
    endtask

    task automatic check_px(input string n, input logic [9:0] h, input logic [9:0] v,
                            input logic b, input logic hs, input logic vs,
                            input logic [2:0] r, input logic [2:0] g, input logic [1:0] bl);
        drive(h, v, b, hs, vs);
        exp_q.push_back({r, g, bl, hs, vs});
        name_q.push_back(n);
        scramble();
    endtask

    task automatic frame_start();
        tick_only(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
        tick_only(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset has priority even while a tick samples active-low syncs.
        hsync = 1'b0;
        vsync = 1'b0;
        blank = 1'b0;
        mode  = 2'b11;
        repeat (4) @(posedge clk);
        #1;
        check_val("reset_rgb", int'({red, green, blue}), 0);
        check_val("reset_sync", int'({hsync_o, vsync_o}), 3);
        check_val("reset_frame_cnt", int'(frame_cnt), 0);
        @(negedge clk);
        hsync = 1'b1;
        vsync = 1'b1;
        mode  = 2'b00;
        reset = 1'b0;

        // Colour bars.
        frame_start();
        check_val("frame_cnt_1", int'(frame_cnt), 1);
        check_px("bars_i3", 10'd250, 10'd100, 1'b0, 1'b1, 1'b0, 3'd0, 3'd7, 2'd3);
        check_px("bars_i0", 10'd0, 10'd100, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0);
        check_px("bars_i1", 10'd80, 10'd100, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd3);
        check_px("bars_i5", 10'd479, 10'd100, 1'b0, 1'b1, 1'b0, 3'd7, 3'd0, 2'd3);
        check_px("bars_i7", 10'd639, 10'd100, 1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 2'd3);
        check_px("hsync_align", 10'd250, 10'd100, 1'b0, 1'b0, 1'b0, 3'd0, 3'd7, 2'd3);
        check_px("bars_blank", 10'd250, 10'd100, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0);

        // Mode change mid-frame waits for the next frame start.
        frame_start();
        frame_start();
        check_val("frame_cnt_3", int'(frame_cnt), 3);
        mode = 2'b01;
        check_px("latch_still_bars", 10'd32, 10'd0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0);
        frame_start();
        check_val("frame_cnt_4", int'(frame_cnt), 4);
        check_px("checker_white", 10'd32, 10'd0, 1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 2'd3);
        check_px("checker_black", 10'd32, 10'd32, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0);

        // Solid white with blanking.
        mode = 2'b11;
        frame_start();
        check_px("white_blank", 10'd100, 10'd100, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0);
        check_px("white", 10'd100, 10'd100, 1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 2'd3);

        // Reset mid-frame after 5 frames.
        tick_only(10'd5, 10'd5, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        hsync = 1'b0;
        vsync = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("midreset_frame_cnt", int'(frame_cnt), 0);
        check_val("midreset_sync", int'({hsync_o, vsync_o}), 3);
        check_val("midreset_rgb", int'({red, green, blue}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        hsync = 1'b1;
        vsync = 1'b1;
        mode  = 2'b10;
        reset = 1'b0;
        frame_start();
        check_val("after_reset_frame_cnt", int'(frame_cnt), 1);
        check_px("box_tl", 10'd2, 10'd2, 1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 2'd3);
        check_px("box_left_out", 10'd1, 10'd2, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd3);
        check_px("box_br", 10'd33, 10'd33, 1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 2'd3);
        check_px("box_right_out", 10'd34, 10'd2, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd3);

        // 304 frame starts in total: x reaches 608 and turns, y is 288 going up.
        repeat (303) frame_start();
        check_val("frame_cnt_wrap", int'(frame_cnt), 48);
        check_px("box608_tl", 10'd608, 10'd288, 1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 2'd3);
        check_px("box608_left", 10'd607, 10'd288, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd3);
        check_px("box608_br", 10'd639, 10'd319, 1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 2'd3);
        check_px("box608_below", 10'd639, 10'd320, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd3);
        frame_start();
        check_px("box606_tl", 10'd606, 10'd286, 1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 2'd3);
        check_px("box606_right", 10'd638, 10'd300, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd3);
        check_px("box606_br", 10'd637, 10'd317, 1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 2'd3);
        check_px("box606_below", 10'd637, 10'd318, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 2'd3);

        repeat (4) @(negedge clk);
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
